esc_pwm_multi: RTL and testbench

Parametrised multi-channel ESC pulse generator: one shared frame counter drives NUM_CH independent servo-style PWM outputs, one per motor ESC. Each channel's pulse width is MIN_PULSE plus the scaled sum of its speed command and trim offset, saturated at MAX_PULSE. New commands are double-buffered and applied only at frame boundaries, so no pulse is ever truncated or stretched mid-frame. The block adds an arm gate and a per-frame slew limiter. It sits between the flight controller's motor-mix outputs and the ESC pins.

---
 rtl/esc_pwm_multi.sv | 169 ++++++++++++++++
 tb/tb_esc_pwm_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_pwm_multi.sv
// esc_pwm_multi: multi-channel servo-style ESC pulse generator.
//
// One shared frame counter (cnt, 0..FRAME_CYCLES-1) drives NUM_CH independent
// PWM outputs. Each channel's width is MIN_PULSE + ((speed + off) << SCALE_SHIFT),
// saturated at MAX_PULSE, optionally slew-limited by RAMP_STEP per frame, and
// forced to MIN_PULSE while disarmed. Commands are double-buffered: load captures
// them into pending registers and they only reach the pulse at a frame boundary.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   arm         1 = commanded widths, 0 = idle pulses (sampled at frame boundary)
//   load        single-cycle strobe capturing speed/off into pending registers
//   speed       NUM_CH x SPEED_W unsigned speed commands, channel i at [i*SPEED_W +: SPEED_W]
//   off         NUM_CH x OFF_W unsigned trim offsets, same packing
//   pwm         NUM_CH registered pulse outputs
//   frame_sync  one-cycle pulse on the first high cycle of each frame
//   sat         NUM_CH sticky saturation flags, cleared by load

// Per-channel slice: pending command registers, target/slew computation,
// active width register and pulse comparator.
module esc_pwm_chan #(
    parameter int SPEED_W     = 11,
    parameter int OFF_W       = 10,
    parameter int CNT_W       = 20,
    parameter int MIN_PULSE   = 50_000,
    parameter int MAX_PULSE   = 100_000,
    parameter int SCALE_SHIFT = 4,
    parameter int RAMP_STEP   = 2_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               boundary,
    input  logic               arm,
    input  logic               armed_q,
    input  logic               load,
    input  logic [SPEED_W-1:0] speed,
    input  logic [OFF_W-1:0]   off,
    output logic               pwm,
    output logic               sat
);
    localparam int RAW_W  = CNT_W + 1;
    localparam int COMP_W = SPEED_W + 1;
    localparam logic [RAW_W-1:0] MIN_R  = RAW_W'(MIN_PULSE);
    localparam logic [RAW_W-1:0] MAX_R  = RAW_W'(MAX_PULSE);
    localparam logic [RAW_W-1:0] STEP_R = RAW_W'(RAMP_STEP);

    logic [SPEED_W-1:0] pend_speed;
    logic [OFF_W-1:0]   pend_off;
    logic [CNT_W-1:0]   active_w;
    logic [COMP_W-1:0]  comp;
    logic [RAW_W-1:0]   raw;
    logic [RAW_W-1:0]   target;
    logic [RAW_W-1:0]   base;
    logic [RAW_W-1:0]   next_w;
    logic               over;

    always_comb begin
        comp   = COMP_W'(pend_speed) + COMP_W'(pend_off);
        raw    = MIN_R + (RAW_W'(comp) << SCALE_SHIFT);
        over   = (raw > MAX_R);
        target = over ? MAX_R : raw;
        // After a disarmed frame the ramp restarts from the idle width.
        base   = armed_q ? {1'b0, active_w} : MIN_R;
        if (!arm)
            next_w = MIN_R;
        else if (RAMP_STEP == 0)
            next_w = target;
        // Step by RAMP_STEP only while the gap exceeds it, so we land on
        // target exactly and never wrap or overshoot.
        else if (target > base)
            next_w = ((target - base) > STEP_R) ? base + STEP_R : target;
        else
            next_w = ((base - target) > STEP_R) ? base - STEP_R : target;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_speed <= '0;
            pend_off   <= '0;
            active_w   <= CNT_W'(MIN_PULSE);
            pwm        <= 1'b0;
            sat        <= 1'b0;
        end else begin
            pwm <= (cnt < active_w);
            if (load) begin
                pend_speed <= speed;
                pend_off   <= off;
            end
            // next_w always fits CNT_W because MAX_PULSE < FRAME_CYCLES.
            if (boundary)
                active_w <= CNT_W'(next_w);
            // A load clears the flag; a boundary in the same cycle evaluated
            // the previous command, which the load just superseded.
            if (load)
                sat <= 1'b0;
            else if (boundary && over)
                sat <= 1'b1;
        end
    end
endmodule

module esc_pwm_multi #(
    parameter int NUM_CH       = 4,
    parameter int SPEED_W      = 11,
    parameter int OFF_W        = 10,
    parameter int FRAME_CYCLES = 1_000_000,
    parameter int MIN_PULSE    = 50_000,
    parameter int MAX_PULSE    = 100_000,
    parameter int SCALE_SHIFT  = 4,
    parameter int RAMP_STEP    = 2_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm,
    input  logic                      load,
    input  logic [NUM_CH*SPEED_W-1:0] speed,
    input  logic [NUM_CH*OFF_W-1:0]   off,
    output logic [NUM_CH-1:0]         pwm,
    output logic                      frame_sync,
    output logic [NUM_CH-1:0]         sat
);
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             armed_q;
    logic             boundary;

    assign boundary = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            armed_q    <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            cnt        <= boundary ? '0 : cnt + 1'b1;
            frame_sync <= (cnt == '0);
            if (boundary)
                armed_q <= arm;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pwm_chan #(
            .SPEED_W    (SPEED_W),
            .OFF_W      (OFF_W),
            .CNT_W      (CNT_W),
            .MIN_PULSE  (MIN_PULSE),
            .MAX_PULSE  (MAX_PULSE),
            .SCALE_SHIFT(SCALE_SHIFT),
            .RAMP_STEP  (RAMP_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cnt     (cnt),
            .boundary(boundary),
            .arm     (arm),
            .armed_q (armed_q),
            .load    (load),
            .speed   (speed[i*SPEED_W +: SPEED_W]),
            .off     (off[i*OFF_W +: OFF_W]),
            .pwm     (pwm[i]),
            .sat     (sat[i])
        );
    end
endmodule

// File: tb/tb_esc_pwm_multi.sv
// Scoreboard bench for esc_pwm_multi. Two instances share all inputs: one with
// slew limiting disabled, one with a small RAMP_STEP. A reference model tracks
// frame position, pending commands and per-frame widths with integer arithmetic
// and pushes each frame's expected widths into a queue; a monitor measures the
// high-cycle count of every pulse between frame_sync pulses and compares.
module tb_esc_pwm_multi;
    localparam int NCH  = 4;
    localparam int SW   = 6;
    localparam int OW   = 4;
    localparam int F    = 200;
    localparam int MINP = 40;
    localparam int MAXP = 150;
    localparam int SH   = 1;
    localparam int R1   = 7;

    typedef logic [1:0][NCH-1:0][15:0] wv_t;

    logic               clk = 1'b0;
    logic               rst_n, arm, load;
    logic [NCH*SW-1:0]  speed;
    logic [NCH*OW-1:0]  off;
    logic [NCH-1:0]     pwm0, pwm1, sat0, sat1;
    logic               fs0, fs1;
    logic [1:0][NCH-1:0] pwm_all, sat_all;

    assign pwm_all = {pwm1, pwm0};
    assign sat_all = {sat1, sat0};

    always #5 clk = ~clk;

    esc_pwm_multi #(.NUM_CH(NCH), .SPEED_W(SW), .OFF_W(OW), .FRAME_CYCLES(F),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SCALE_SHIFT(SH), .RAMP_STEP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .load(load), .speed(speed), .off(off),
        .pwm(pwm0), .frame_sync(fs0), .sat(sat0));

    esc_pwm_multi #(.NUM_CH(NCH), .SPEED_W(SW), .OFF_W(OW), .FRAME_CYCLES(F),
        .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .SCALE_SHIFT(SH), .RAMP_STEP(R1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .load(load), .speed(speed), .off(off),
        .pwm(pwm1), .frame_sync(fs1), .sat(sat1));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          mcnt;
    int          ps[NCH];
    int          po[NCH];
    int          mw[2][NCH];
    int          rs[2] = '{0, R1};
    logic [1:0][NCH-1:0] msat;
    logic        exp_fs = 1'b0;
    bit          rst_seen = 1'b0;
    wv_t         exq[$];

    function automatic wv_t pack_w();
        wv_t e;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++)
                e[d][c] = 16'(mw[d][c]);
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mcnt   = 0;
                exp_fs = 1'b0;
                msat   = '0;
                for (int c = 0; c < NCH; c++) begin
                    ps[c] = 0;
                    po[c] = 0;
                    for (int d = 0; d < 2; d++) mw[d][c] = MINP;
                end
                exq.delete();
                exq.push_back(pack_w());
                rst_seen = 1'b1;
            end else begin
                exp_fs = (mcnt == 0);
                if (mcnt == F - 1) begin
                    for (int d = 0; d < 2; d++)
                        for (int c = 0; c < NCH; c++) begin
                            int raw, tgt;
                            raw = MINP + (ps[c] + po[c]) * (1 << SH);
                            tgt = (raw > MAXP) ? MAXP : raw;
                            if (raw > MAXP && !load) msat[d][c] = 1'b1;
                            if (!arm)
                                mw[d][c] = MINP;
                            else if (rs[d] == 0)
                                mw[d][c] = tgt;
                            else if (tgt > mw[d][c])
                                mw[d][c] = (tgt - mw[d][c] > rs[d]) ? mw[d][c] + rs[d] : tgt;
                            else
                                mw[d][c] = (mw[d][c] - tgt > rs[d]) ? mw[d][c] - rs[d] : tgt;
                        end
                    exq.push_back(pack_w());
                end
                if (load) begin
                    msat = '0;
                    for (int c = 0; c < NCH; c++) begin
                        ps[c] = int'(speed[c*SW +: SW]);
                        po[c] = int'(off[c*OW +: OW]);
                    end
                end
                mcnt = (mcnt == F - 1) ? 0 : mcnt + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int  hc[2][NCH];
    wv_t cur;
    bit  has_cur = 1'b0;
    int  wd = 0;
    bit  to_rep = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                has_cur  = 1'b0;
                rst_seen = 1'b0;
                wd       = 0;
            end
            chk("frame_sync ramp0", 32'(fs0), 32'(exp_fs));
            chk("frame_sync ramp1", 32'(fs1), 32'(exp_fs));
            if (exp_fs) begin
                if (has_cur) begin
                    for (int d = 0; d < 2; d++)
                        for (int c = 0; c < NCH; c++)
                            chk($sformatf("width dut%0d ch%0d", d, c), 32'(hc[d][c]), 32'(cur[d][c]));
                end
                chk("sat", 32'(sat_all), 32'(msat));
                if (exq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard: frame started with no expected entry");
                    has_cur = 1'b0;
                end else begin
                    cur     = exq.pop_front();
                    has_cur = 1'b1;
                end
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < NCH; c++) hc[d][c] = 0;
                wd = 0;
            end
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NCH; c++)
                    if (pwm_all[d][c] === 1'b1) hc[d][c]++;
            wd++;
            if (wd > F + 4 && !to_rep) begin
                n_chk++;
                n_fail++;
                to_rep = 1'b1;
                $display("FAIL frame timeout: %0d cycles without frame start, limit %0d", wd, F + 4);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_load(input logic [NCH*SW-1:0] s, input logic [NCH*OW-1:0] o);
        @(negedge clk);
        load  = 1'b1;
        speed = s;
        off   = o;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int guard = 0;
        while (mcnt != v && guard < 2 * F) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        logic [NCH*SW-1:0] s;
        logic [NCH*OW-1:0] o;
        rst_n = 1'b0; arm = 1'b0; load = 1'b0; speed = '0; off = '0;
        repeat (3) @(negedge clk);
        chk("reset pwm", 32'(pwm_all), 32'd0);
        chk("reset frame_sync", 32'({fs1, fs0}), 32'd0);
        chk("reset sat", 32'(sat_all), 32'd0);
        rst_n = 1'b1;
        repeat (2 * F) @(negedge clk);

        // Armed: ch0 -> 66-equivalent, ch2 saturates, mid-frame load.
        arm = 1'b1;
        wait_cnt(60);
        s = '0; o = '0;
        s[0*SW +: SW] = 6'd13;
        s[1*SW +: SW] = 6'd30; o[1*OW +: OW] = 4'd9;
        s[2*SW +: SW] = 6'd63; o[2*OW +: OW] = 4'd15;
        do_load(s, o);
        repeat (5 * F) @(negedge clk);
        do_load('0, '0);
        repeat (4 * F) @(negedge clk);
        do_load(s, o);
        repeat (4 * F) @(negedge clk);

        // Disarm mid-pulse, then re-arm.
        wait_cnt(20);
        arm = 1'b0;
        repeat (2 * F) @(negedge clk);
        arm = 1'b1;
        repeat (3 * F) @(negedge clk);

        // Load exactly in the boundary cycle.
        wait_cnt(F - 1);
        load = 1'b1;
        speed = {$urandom} % (1 << (NCH*SW));
        off   = 16'($urandom);
        @(negedge clk);
        load = 1'b0;
        repeat (3 * F) @(negedge clk);

        // Randomized commands and arm toggling.
        for (int i = 0; i < 40 * F; i++) begin
            @(negedge clk);
            load = 1'b0;
            if ($urandom_range(0, 149) == 0) begin
                load = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    speed[c*SW +: SW] = SW'($urandom);
                    off[c*OW +: OW]   = OW'($urandom);
                end
            end
            if ($urandom_range(0, 1499) == 0) arm = ~arm;
        end
        @(negedge clk);
        load = 1'b0;
        arm  = 1'b1;
        repeat (2 * F) @(negedge clk);

        // One-cycle reset during a high pulse.
        wait_cnt(10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset pwm", 32'(pwm_all), 32'd0);
        chk("midreset sat", 32'(sat_all), 32'd0);
        rst_n = 1'b1;
        repeat (3 * F + 5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
